johnson_seq_checker: RTL and testbench
======================================

// Module: johnson_seq_checker
// PURPOSE
//  Receive-side companion to the Johnson counter. Samples an N-bit Johnson code, decodes it to a position index,
//  and checks that each code is legal and is the successor of the previous one.
//  Locks after LOCK_CNT consecutive good steps; reports errors; keeps a saturating error count.
//  Sits between a Johnson-counter output bus and status/debug logic.
// PARAMETERS
//  N         4   Johnson register width; sequence length 2N, positions 0..2N-1
//  LOCK_CNT  3   consecutive in-order legal samples required to assert locked (1..2N)
//  ERR_W     8   width of err_cnt
// PORTS
//  clk      in   1                  rising-edge clock
//  clr_n    in   1                  asynchronous, active-low reset
//  en       in   1                  q holds a new sample this cycle (one counter step)
//  q        in   N                  Johnson code, q[0] = LSB stage
//  clr_err  in   1                  synchronous clear of err_cnt
//  idx      out  $clog2(2N)         decoded position of last legal sample
//  idx_vld  out  1                  1-cycle pulse: idx updated from a legal sample
//  locked   out  1                  sequence tracking established
//  code_err out  1                  1-cycle pulse: illegal code sampled
//  seq_err  out  1                  1-cycle pulse: legal code, but not successor (ACQUIRE/LOCKED only)
//  err_cnt  out  ERR_W              saturating count of code_err + seq_err events
// BEHAVIOUR
//  - Reset (clr_n=0, async, no clock needed): state=UNLOCKED, idx=0, all pulses 0, locked=0, err_cnt=0, good=0.
//  - Code table (N=4): 0000=0, 0001=1, 0011=2, 0111=3, 1111=4, 1110=5, 1100=6, 1000=7.
//  - Legal code: q[N-1]=0 and q is contiguous ones from bit0 (incl. all-zero),
//    or q[N-1]=1 and ~q is contiguous ones from bit0.
//  - Decode: q[N-1]=0 -> idx=popcount(q); q[N-1]=1 -> idx=2N-popcount(q).
//  - Successor: (prev+1) mod 2N; the wrap 2N-1 -> 0 is legal.
//  - Latency: the sample presented with en at edge t is reflected in all outputs after edge t (registered).
//  - en=0: state, idx, good, and err_cnt hold; idx_vld, code_err, and seq_err are 0.
//  - FSM, evaluated only when en=1:
//    UNLOCKED: legal -> ACQUIRE, good=1, prev=idx. Illegal -> code_err, stay.
//    ACQUIRE:  legal successor -> good+1; at good+1==LOCK_CNT -> LOCKED, locked=1.
//              legal non-successor -> seq_err, good=1, stay.
//              illegal -> code_err, UNLOCKED, good=0.
//    LOCKED:   legal successor -> stay.
//              legal non-successor -> seq_err, ACQUIRE, good=1, locked=0.
//              illegal -> code_err, UNLOCKED, locked=0.
//  - A legal sample always updates idx/prev and pulses idx_vld, even with seq_err.
//    An illegal sample leaves idx unchanged.
//  - err_cnt: +1 per error pulse, saturates at 2^ERR_W-1.
//    clr_err alone -> 0. clr_err with a simultaneous error -> 1.
//  - LOCK_CNT=1: the first legal sample goes straight to LOCKED.
// STRUCTURE
//  - Shared package johnson_pkg: state localparams (UNLOCKED=0, ACQUIRE=1, LOCKED=2),
//    plus functions jc_legal(q) and jc_decode(q). The counter RTL and this checker both use these.
//  - Sub-module johnson_code_decode (combinational): q -> {legal, idx}.
//  - Top level holds the FSM, the prev/idx registers, the good counter, and err_cnt.
// TESTING (N=4, LOCK_CNT=3, ERR_W=8 unless noted)
//  1. Reset, then 8 en samples 0000..1000 -> idx 0..7 with idx_vld each; locked=1 after the 3rd sample edge; no errors.
//  2. Locked, en with q=0101 -> code_err=1 for 1 cycle, idx_vld=0, locked=0, state UNLOCKED, err_cnt=1.
//  3. Locked at idx=2 (0011), next q=1111 -> seq_err=1, idx=4, idx_vld=1, locked=0, ACQUIRE; 2 more successors -> locked=1.
//  4. Locked at 1000 (idx 7), next q=0000 -> idx=0, no error, locked stays 1.
//  5. ERR_W=2: 5 illegal samples -> err_cnt=3 (saturated); clr_err with an illegal sample in the same cycle -> err_cnt=1.
//  6. In ACQUIRE, drop clr_n between clock edges -> all outputs 0 immediately;
//     release -> first legal sample enters ACQUIRE, good=1.

Source files
------------

// File: rtl/johnson_pkg.sv
// Shared Johnson-code definitions: tracking states and code helpers used by
// both the counter and the receive-side checker.
package johnson_pkg;

    // Widest Johnson register the helper functions accept.
    localparam int JC_MAX_W = 32;

    // Tracking states of the sequence checker.
    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } jc_state_e;

    // Mask covering the low n bits of a JC_MAX_W-wide vector.
    function automatic logic [JC_MAX_W-1:0] jc_mask(input int n);
        if (n >= JC_MAX_W) begin
            return '1;
        end
        return (JC_MAX_W'(1) << n) - JC_MAX_W'(1);
    endfunction

    // Most significant stage of an n-bit code.
    function automatic logic jc_msb(input logic [JC_MAX_W-1:0] q, input int n);
        return |(q & (JC_MAX_W'(1) << (n - 1)));
    endfunction

    // A code is legal when, after inverting codes whose top stage is set,
    // what remains is a run of ones starting at bit 0 (possibly empty).
    function automatic logic jc_legal(input logic [JC_MAX_W-1:0] q, input int n);
        logic [JC_MAX_W-1:0] mask;
        logic [JC_MAX_W-1:0] v;
        mask = jc_mask(n);
        v    = jc_msb(q, n) ? (~q & mask) : (q & mask);
        return ((v & (v + JC_MAX_W'(1))) == '0) && ((q & ~mask) == '0);
    endfunction

    // Position of a legal code in the 2n-step sequence.
    function automatic int jc_decode(input logic [JC_MAX_W-1:0] q, input int n);
        int pc;
        pc = $countones(q & jc_mask(n));
        return jc_msb(q, n) ? (2 * n - pc) : pc;
    endfunction

endpackage

// File: rtl/johnson_seq_checker_if.sv
// Sample/status bundle between a Johnson-counter bus and the sequence checker.
interface johnson_seq_checker_if #(
    parameter int N     = 4,
    parameter int ERR_W = 8
);
    localparam int IDX_W = $clog2(2 * N);

    logic             en;
    logic [N-1:0]     q;
    logic             clr_err;
    logic [IDX_W-1:0] idx;
    logic             idx_vld;
    logic             locked;
    logic             code_err;
    logic             seq_err;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output en, q, clr_err,
        input  idx, idx_vld, locked, code_err, seq_err, err_cnt
    );

    modport slave (
        input  en, q, clr_err,
        output idx, idx_vld, locked, code_err, seq_err, err_cnt
    );
endinterface

// File: rtl/johnson_code_decode.sv
// Combinational Johnson-code classifier: legality flag and position index.
module johnson_code_decode
    import johnson_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(2 * N)
) (
    input  logic [N-1:0]     q,
    output logic             legal,
    output logic [IDX_W-1:0] idx
);

    logic [JC_MAX_W-1:0] q_ext;

    // Widen to the helper width, then classify and decode.
    always_comb begin
        q_ext = JC_MAX_W'(q);
        legal = jc_legal(q_ext, N);
        idx   = IDX_W'(jc_decode(q_ext, N));
    end

endmodule

// File: rtl/johnson_seq_checker.sv
// Receive-side Johnson sequence checker: decodes each sample, tracks
// in-order progress, locks after LOCK_CNT good steps and counts errors.
module johnson_seq_checker
    import johnson_pkg::*;
#(
    parameter int N        = 4,
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic                   clk,
    input  logic                   clr_n,
    johnson_seq_checker_if.slave   bus
);

    localparam int IDX_W  = $clog2(2 * N);
    localparam int GOOD_W = $clog2(2 * N + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(2 * N - 1);
    localparam logic [GOOD_W-1:0] LOCK_TGT = GOOD_W'(LOCK_CNT);
    localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

    jc_state_e         state_reg, state_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;       // doubles as the previous position
    logic [GOOD_W-1:0] good_reg, good_next;
    logic [ERR_W-1:0]  err_cnt_reg, err_cnt_next;
    logic              idx_vld_reg, idx_vld_next;
    logic              code_err_reg, code_err_next;
    logic              seq_err_reg, seq_err_next;

    logic              dec_legal;
    logic [IDX_W-1:0]  dec_idx;
    logic [IDX_W-1:0]  succ_idx;
    logic              is_succ;
    logic [GOOD_W-1:0] good_inc;

    johnson_code_decode #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_decode (
        .q     (bus.q),
        .legal (dec_legal),
        .idx   (dec_idx)
    );

    // Tracking FSM: next state, position, good-step count and event pulses.
    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        good_next     = good_reg;
        idx_vld_next  = 1'b0;
        code_err_next = 1'b0;
        seq_err_next  = 1'b0;
        succ_idx      = (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);
        is_succ       = (dec_idx == succ_idx);
        good_inc      = good_reg + GOOD_W'(1);

        if (bus.en) begin
            if (!dec_legal) begin
                code_err_next = 1'b1;
                state_next    = UNLOCKED;
                good_next     = '0;
            end else begin
                idx_vld_next = 1'b1;
                idx_next     = dec_idx;
                unique case (state_reg)
                    UNLOCKED: begin
                        good_next  = GOOD_W'(1);
                        state_next = (LOCK_CNT == 1) ? LOCKED : ACQUIRE;
                    end
                    ACQUIRE: begin
                        if (is_succ) begin
                            good_next = good_inc;
                            if (good_inc >= LOCK_TGT) begin
                                state_next = LOCKED;
                            end
                        end else begin
                            seq_err_next = 1'b1;
                            good_next    = GOOD_W'(1);
                        end
                    end
                    LOCKED: begin
                        if (!is_succ) begin
                            seq_err_next = 1'b1;
                            state_next   = ACQUIRE;
                            good_next    = GOOD_W'(1);
                        end
                    end
                    default: begin
                        state_next = UNLOCKED;
                        good_next  = '0;
                    end
                endcase
            end
        end
    end

    // Saturating error counter; a clear that coincides with an error leaves one count.
    always_comb begin
        err_cnt_next = err_cnt_reg;
        if (bus.clr_err) begin
            err_cnt_next = (code_err_next || seq_err_next) ? ERR_W'(1) : '0;
        end else if ((code_err_next || seq_err_next) && (err_cnt_reg != ERR_MAX)) begin
            err_cnt_next = err_cnt_reg + ERR_W'(1);
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_reg    <= UNLOCKED;
            idx_reg      <= '0;
            good_reg     <= '0;
            err_cnt_reg  <= '0;
            idx_vld_reg  <= 1'b0;
            code_err_reg <= 1'b0;
            seq_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            good_reg     <= good_next;
            err_cnt_reg  <= err_cnt_next;
            idx_vld_reg  <= idx_vld_next;
            code_err_reg <= code_err_next;
            seq_err_reg  <= seq_err_next;
        end
    end

    assign bus.idx      = idx_reg;
    assign bus.idx_vld  = idx_vld_reg;
    assign bus.locked   = (state_reg == LOCKED);
    assign bus.code_err = code_err_reg;
    assign bus.seq_err  = seq_err_reg;
    assign bus.err_cnt  = err_cnt_reg;

endmodule

// File: tb/tb_johnson_seq_checker.sv
// Bench for johnson_seq_checker: table vectors, hand-written corner cases and
// randomized samples against a position-table reference model.
module tb_johnson_seq_checker;

    logic clk;
    logic clr_n;

    johnson_seq_checker_if #(.N(4), .ERR_W(8)) bus8 ();
    johnson_seq_checker_if #(.N(4), .ERR_W(2)) bus2 ();

    johnson_seq_checker #(.N(4), .LOCK_CNT(3), .ERR_W(8)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus8)
    );

    johnson_seq_checker #(.N(4), .LOCK_CNT(3), .ERR_W(2)) dut2 (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: tracking mode 0=unlocked 1=acquire 2=locked.
    int m_mode, m_idx, m_good, m_cnt8, m_cnt2;
    int m_vld, m_cerr, m_serr;

    typedef struct {
        logic       en;
        logic [3:0] q;
        logic       clr;
        int         e_idx;
        int         e_vld;
        int         e_lock;
        int         e_cerr;
        int         e_serr;
        int         e_cnt;
    } vec_t;

    vec_t tbl[21];

    function automatic logic [3:0] code_of(input int p);
        logic [3:0] ones;
        if (p <= 4) begin
            ones = 4'((1 << p) - 1);
            return ones;
        end
        ones = 4'((1 << (p - 4)) - 1);
        return 4'hF ^ ones;
    endfunction

    function automatic int pos_of(input logic [3:0] q);
        for (int p = 0; p < 8; p++) begin
            if (code_of(p) == q) return p;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_idx = 0; m_good = 0; m_cnt8 = 0; m_cnt2 = 0;
        m_vld = 0; m_cerr = 0; m_serr = 0;
    endtask

    task automatic model_step(input logic en, input logic [3:0] q, input logic clr);
        int p;
        int ev;
        m_vld = 0; m_cerr = 0; m_serr = 0;
        if (en) begin
            p = pos_of(q);
            if (p < 0) begin
                m_cerr = 1; m_mode = 0; m_good = 0;
            end else begin
                m_vld = 1;
                if (m_mode == 0) begin
                    m_good = 1; m_mode = 1;
                end else if (p == (m_idx + 1) % 8) begin
                    if (m_mode == 1) begin
                        m_good++;
                        if (m_good >= 3) m_mode = 2;
                    end
                end else begin
                    m_serr = 1; m_mode = 1; m_good = 1;
                end
                m_idx = p;
            end
        end
        ev = m_cerr + m_serr;
        if (clr) begin
            m_cnt8 = ev; m_cnt2 = ev;
        end else if (ev != 0) begin
            m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
            m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One sample on both checkers; returns #1 after the capturing edge.
    task automatic apply(input logic en, input logic [3:0] q, input logic clr);
        @(negedge clk);
        bus8.en = en; bus8.q = q; bus8.clr_err = clr;
        bus2.en = en; bus2.q = q; bus2.clr_err = clr;
        @(posedge clk);
        model_step(en, q, clr);
        #1;
        $display("txn en=%0b q=%b clr=%0b -> idx=%0d vld=%0b lk=%0b ce=%0b se=%0b cnt=%0d cnt2=%0d",
                 en, q, clr, bus8.idx, bus8.idx_vld, bus8.locked, bus8.code_err,
                 bus8.seq_err, bus8.err_cnt, bus2.err_cnt);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_idx"},  int'(bus8.idx), 0);
        check({tag, "_vld"},  int'(bus8.idx_vld), 0);
        check({tag, "_lock"}, int'(bus8.locked), 0);
        check({tag, "_cerr"}, int'(bus8.code_err), 0);
        check({tag, "_serr"}, int'(bus8.seq_err), 0);
        check({tag, "_cnt"},  int'(bus8.err_cnt), 0);
        check({tag, "_cnt2"}, int'(bus2.err_cnt), 0);
    endtask

    // Asynchronous clear asserted between edges, outputs checked before any edge.
    task automatic reset_pulse(input string tag);
        @(negedge clk);
        bus8.en = 1'b0; bus2.en = 1'b0;
        bus8.clr_err = 1'b0; bus2.clr_err = 1'b0;
        #2 clr_n = 1'b0;
        #1 check_zero(tag);
        model_reset();
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    initial begin
        logic [3:0] rq;
        logic       ren, rclr;
        int         r;

        clr_n = 1'b0;
        bus8.en = 1'b0; bus8.q = 4'b0000; bus8.clr_err = 1'b0;
        bus2.en = 1'b0; bus2.q = 4'b0000; bus2.clr_err = 1'b0;
        model_reset();
        #12 check_zero("reset");
        @(negedge clk);
        clr_n = 1'b1;

        // en q clr | idx vld lock cerr serr cnt
        tbl[0]  = '{1'b1, 4'b0000, 1'b0, 0, 1, 0, 0, 0, 0};
        tbl[1]  = '{1'b1, 4'b0001, 1'b0, 1, 1, 0, 0, 0, 0};
        tbl[2]  = '{1'b1, 4'b0011, 1'b0, 2, 1, 1, 0, 0, 0};
        tbl[3]  = '{1'b1, 4'b0111, 1'b0, 3, 1, 1, 0, 0, 0};
        tbl[4]  = '{1'b1, 4'b1111, 1'b0, 4, 1, 1, 0, 0, 0};
        tbl[5]  = '{1'b1, 4'b1110, 1'b0, 5, 1, 1, 0, 0, 0};
        tbl[6]  = '{1'b1, 4'b1100, 1'b0, 6, 1, 1, 0, 0, 0};
        tbl[7]  = '{1'b1, 4'b1000, 1'b0, 7, 1, 1, 0, 0, 0};
        tbl[8]  = '{1'b1, 4'b0000, 1'b0, 0, 1, 1, 0, 0, 0};
        tbl[9]  = '{1'b1, 4'b0101, 1'b0, 0, 0, 0, 1, 0, 1};
        tbl[10] = '{1'b0, 4'b0011, 1'b0, 0, 0, 0, 0, 0, 1};
        tbl[11] = '{1'b1, 4'b0000, 1'b0, 0, 1, 0, 0, 0, 1};
        tbl[12] = '{1'b1, 4'b0001, 1'b0, 1, 1, 0, 0, 0, 1};
        tbl[13] = '{1'b1, 4'b0011, 1'b0, 2, 1, 1, 0, 0, 1};
        tbl[14] = '{1'b1, 4'b1111, 1'b0, 4, 1, 0, 0, 1, 2};
        tbl[15] = '{1'b1, 4'b1110, 1'b0, 5, 1, 0, 0, 0, 2};
        tbl[16] = '{1'b1, 4'b1100, 1'b0, 6, 1, 1, 0, 0, 2};
        tbl[17] = '{1'b0, 4'b0000, 1'b1, 6, 0, 1, 0, 0, 0};
        tbl[18] = '{1'b1, 4'b1100, 1'b0, 6, 1, 0, 0, 1, 1};
        tbl[19] = '{1'b1, 4'b1000, 1'b0, 7, 1, 0, 0, 0, 1};
        tbl[20] = '{1'b1, 4'b0000, 1'b0, 0, 1, 1, 0, 0, 1};

        for (int i = 0; i < 21; i++) begin
            apply(tbl[i].en, tbl[i].q, tbl[i].clr);
            check($sformatf("tbl%0d_idx", i),  int'(bus8.idx),      tbl[i].e_idx);
            check($sformatf("tbl%0d_vld", i),  int'(bus8.idx_vld),  tbl[i].e_vld);
            check($sformatf("tbl%0d_lock", i), int'(bus8.locked),   tbl[i].e_lock);
            check($sformatf("tbl%0d_cerr", i), int'(bus8.code_err), tbl[i].e_cerr);
            check($sformatf("tbl%0d_serr", i), int'(bus8.seq_err),  tbl[i].e_serr);
            check($sformatf("tbl%0d_cnt", i),  int'(bus8.err_cnt),  tbl[i].e_cnt);
        end

        // Narrow counter saturation, then clear coinciding with an error.
        reset_pulse("rst5");
        for (int k = 1; k <= 5; k++) begin
            apply(1'b1, 4'b0101, 1'b0);
            check($sformatf("sat%0d_cnt2", k), int'(bus2.err_cnt), (k < 3) ? k : 3);
            check($sformatf("sat%0d_cnt8", k), int'(bus8.err_cnt), k);
        end
        apply(1'b1, 4'b0101, 1'b1);
        check("clr_err_cnt2", int'(bus2.err_cnt), 1);
        check("clr_err_cnt8", int'(bus8.err_cnt), 1);
        check("clr_err_cerr", int'(bus8.code_err), 1);

        // Clear mid-acquisition, then reacquire from a single legal sample.
        reset_pulse("rst6a");
        apply(1'b1, 4'b0000, 1'b0);
        apply(1'b1, 4'b0001, 1'b0);
        check("acq_lock", int'(bus8.locked), 0);
        check("acq_idx", int'(bus8.idx), 1);
        reset_pulse("rst6b");
        apply(1'b1, 4'b0111, 1'b0);
        check("reacq1_idx", int'(bus8.idx), 3);
        check("reacq1_vld", int'(bus8.idx_vld), 1);
        check("reacq1_lock", int'(bus8.locked), 0);
        apply(1'b1, 4'b1111, 1'b0);
        check("reacq2_lock", int'(bus8.locked), 0);
        apply(1'b1, 4'b1110, 1'b0);
        check("reacq3_lock", int'(bus8.locked), 1);
        check("reacq3_idx", int'(bus8.idx), 5);

        // Randomized samples against the reference model.
        reset_pulse("rst_rnd");
        for (int t = 0; t < 400; t++) begin
            r = $urandom_range(0, 99);
            if (r < 65)      rq = code_of((m_idx + 1) % 8);
            else if (r < 82) rq = code_of($urandom_range(0, 7));
            else             rq = 4'($urandom_range(0, 15));
            ren  = ($urandom_range(0, 9) != 0);
            rclr = ($urandom_range(0, 19) == 0);
            apply(ren, rq, rclr);
            check("rnd_idx",  int'(bus8.idx),      m_idx);
            check("rnd_vld",  int'(bus8.idx_vld),  m_vld);
            check("rnd_lock", int'(bus8.locked),   (m_mode == 2) ? 1 : 0);
            check("rnd_cerr", int'(bus8.code_err), m_cerr);
            check("rnd_serr", int'(bus8.seq_err),  m_serr);
            check("rnd_cnt8", int'(bus8.err_cnt),  m_cnt8);
            check("rnd_cnt2", int'(bus2.err_cnt),  m_cnt2);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
